// File: rtl/axis_width_upsizer_if.sv
// Narrow-in / wide-out AXI-Stream bundle for the width upsizer.
// slave: the converter's view; master: the environment that feeds narrow beats and drains wide beats.
interface axis_width_upsizer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4
);
   logic [DATA_WIDTH-1:0]       s_tdata;
   logic                        s_tvalid;
   logic                        s_tready;
   logic                        s_tlast;
   logic [DATA_WIDTH*RATIO-1:0] m_tdata;
   logic [RATIO-1:0]            m_tkeep;
   logic                        m_tvalid;
   logic                        m_tready;
   logic                        m_tlast;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
   );
endinterface

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow AXI-Stream beats into one wide beat with a lane keep mask;
// tlast closes a wide beat early so packets never share a wide beat.
module axis_width_upsizer #(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4
) (
   input  logic                 aclk,
   input  logic                 areset,
   axis_width_upsizer_if.slave  io_axis
);

   localparam int IDX_W  = $clog2(RATIO);
   localparam int WIDE_W = DATA_WIDTH * RATIO;

   if (RATIO < 2) begin : g_bad_ratio
      $error("axis_width_upsizer: RATIO must be at least 2");
   end

   logic [IDX_W-1:0]  r_idx;
   logic [WIDE_W-1:0] r_acc_data;
   logic [RATIO-1:0]  r_acc_keep;
   logic [WIDE_W-1:0] r_m_tdata;
   logic [RATIO-1:0]  r_m_tkeep;
   logic              r_m_tlast;
   logic              r_m_tvalid;

   logic              w_s_tready;
   logic              w_s_fire;
   logic              w_m_fire;
   logic              w_complete;
   logic [WIDE_W-1:0] w_merged;
   logic [RATIO-1:0]  w_keep_merged;

   // Input only stalls while a held wide beat is not being taken this cycle.
   assign w_s_tready = !areset && (!r_m_tvalid || io_axis.m_tready);
   assign w_s_fire   = io_axis.s_tvalid && w_s_tready;
   assign w_m_fire   = r_m_tvalid && io_axis.m_tready;
   assign w_complete = w_s_fire && ((r_idx == IDX_W'(RATIO - 1)) || io_axis.s_tlast);

   // Lanes above idx are always zero in the accumulator, so the merged word
   // already has its unused upper lanes cleared.
   always_comb begin
      w_merged      = r_acc_data;
      w_keep_merged = r_acc_keep;
      for (int k = 0; k < RATIO; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_merged[k*DATA_WIDTH +: DATA_WIDTH] = io_axis.s_tdata;
            w_keep_merged[k]                     = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_idx      <= '0;
         r_acc_data <= '0;
         r_acc_keep <= '0;
      end else if (w_s_fire) begin
         if (w_complete) begin
            r_idx      <= '0;
            r_acc_data <= '0;
            r_acc_keep <= '0;
         end else begin
            r_idx      <= r_idx + 1'b1;
            r_acc_data <= w_merged;
            r_acc_keep <= w_keep_merged;
         end
      end
   end

   // A completion can only occur when the output slot is empty or draining,
   // so loading takes priority and gives back-to-back wide beats.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_m_tdata  <= '0;
         r_m_tkeep  <= '0;
         r_m_tlast  <= 1'b0;
         r_m_tvalid <= 1'b0;
      end else if (w_complete) begin
         r_m_tdata  <= w_merged;
         r_m_tkeep  <= w_keep_merged;
         r_m_tlast  <= io_axis.s_tlast;
         r_m_tvalid <= 1'b1;
      end else if (w_m_fire) begin
         r_m_tvalid <= 1'b0;
      end
   end

   assign io_axis.s_tready = w_s_tready;
   assign io_axis.m_tdata  = r_m_tdata;
   assign io_axis.m_tkeep  = r_m_tkeep;
   assign io_axis.m_tlast  = r_m_tlast;
   assign io_axis.m_tvalid = r_m_tvalid;

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Bench for axis_width_upsizer: directed scenarios plus random stress, all checked
// against a queue-based packing model sampled on the falling clock edge.
module tb_axis_width_upsizer;

   localparam int DW = 8;
   localparam int R  = 4;
   localparam int WW = DW * R;

   typedef struct packed {
      logic [WW-1:0] data;
      logic [R-1:0]  keep;
      logic          last;
   } wbeat_t;

   logic aclk = 1'b0;
   logic areset;

   axis_width_upsizer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

   axis_width_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
      .aclk    (aclk),
      .areset  (areset),
      .io_axis (bus)
   );

   always #5 aclk = ~aclk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [DW-1:0] part_q[$];
   wbeat_t        exp_q[$];
   wbeat_t        got_q[$];
   int            got_cyc_q[$];
   int            s_cyc_q[$];
   int            s_last_cnt = 0;
   int            m_last_cnt = 0;
   int            lanes_out  = 0;
   wbeat_t        mon_nb;
   logic [R-1:0]  mon_kp1;

   logic mr_force = 1'b0;
   logic mr_rand  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_fail(input string name, input int act, input int exp);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   always @(posedge aclk) cyc <= cyc + 1;

   always @(posedge aclk) begin
      #2;
      bus.m_tready = mr_rand ? ($urandom_range(0, 9) < 7) : mr_force;
   end

   // Reference: collect accepted narrow beats, emit a wide beat when RATIO lanes
   // are gathered or tlast arrives; at most one wide beat may be outstanding.
   always @(negedge aclk) begin
      if (areset) begin
         part_q.delete();
         exp_q.delete();
         chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
         chk("rst_m_tdata",  64'(bus.m_tdata),  64'd0);
         chk("rst_m_tkeep",  64'(bus.m_tkeep),  64'd0);
         chk("rst_m_tlast",  64'(bus.m_tlast),  64'd0);
         chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
      end else begin
         chk("s_tready", 64'(bus.s_tready), 64'(exp_q.size() == 0 || bus.m_tready));
         chk("m_tvalid", 64'(bus.m_tvalid), 64'(exp_q.size() != 0));
         if (bus.m_tvalid && exp_q.size() != 0) begin
            chk("m_tdata", 64'(bus.m_tdata), 64'(exp_q[0].data));
            chk("m_tkeep", 64'(bus.m_tkeep), 64'(exp_q[0].keep));
            chk("m_tlast", 64'(bus.m_tlast), 64'(exp_q[0].last));
            mon_kp1 = bus.m_tkeep + 1'b1;
            chk("keep_contig", 64'(((bus.m_tkeep & mon_kp1) == '0) && (bus.m_tkeep != '0)), 64'd1);
            if (bus.m_tready) begin
               mon_nb.data = bus.m_tdata;
               mon_nb.keep = bus.m_tkeep;
               mon_nb.last = bus.m_tlast;
               got_q.push_back(mon_nb);
               got_cyc_q.push_back(cyc);
               lanes_out += $countones(bus.m_tkeep);
               if (bus.m_tlast) m_last_cnt++;
               void'(exp_q.pop_front());
            end
         end
         if (bus.s_tvalid && bus.s_tready) begin
            part_q.push_back(bus.s_tdata);
            s_cyc_q.push_back(cyc);
            if (bus.s_tlast) s_last_cnt++;
            if (bus.s_tlast || part_q.size() == R) begin
               mon_nb.data = '0;
               for (int i = 0; i < part_q.size(); i++)
                  mon_nb.data = mon_nb.data | (WW'(part_q[i]) << (i * DW));
               mon_nb.keep = R'((1 << part_q.size()) - 1);
               mon_nb.last = bus.s_tlast;
               exp_q.push_back(mon_nb);
               part_q.delete();
            end
         end
      end
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      int waited = 0;
      bus.s_tdata  = d;
      bus.s_tlast  = l;
      bus.s_tvalid = 1'b1;
      forever begin
         @(negedge aclk);
         if (bus.s_tready) begin
            @(posedge aclk); #1;
            break;
         end
         @(posedge aclk); #1;
         waited++;
         if (waited > 500) begin
            flag_fail("send_timeout", waited, 500);
            break;
         end
      end
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge aclk); #1; end
   endtask

   task automatic pulse_reset();
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
   endtask

   task automatic chk_beat(input string name, input int idx, input logic [63:0] d,
                           input logic [63:0] k, input logic [63:0] l);
      if (idx >= got_q.size()) begin
         flag_fail({name, "_present"}, got_q.size(), idx + 1);
         return;
      end
      chk({name, "_data"}, 64'(got_q[idx].data), d);
      chk({name, "_keep"}, 64'(got_q[idx].keep), k);
      chk({name, "_last"}, 64'(got_q[idx].last), l);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int gb, sb, rise_cyc, sent, len, base_sl, base_ml, base_lanes, base_acc, w;
      areset       = 1'b1;
      bus.s_tdata  = '0;
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;

      // Reset values and release
      repeat (3) @(posedge aclk);
      #1;
      @(negedge aclk);
      chk("t1_rst_tready", 64'(bus.s_tready), 64'd0);
      chk("t1_rst_tvalid", 64'(bus.m_tvalid), 64'd0);
      chk("t1_rst_tdata",  64'(bus.m_tdata),  64'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      chk("t1_rel_tready", 64'(bus.s_tready), 64'd1);
      chk("t1_rel_tvalid", 64'(bus.m_tvalid), 64'd0);
      @(posedge aclk); #1;
      idle(3);
      chk("t1_idle_tvalid", 64'(bus.m_tvalid), 64'd0);

      // Full-rate packing
      mr_force = 1'b1;
      gb = got_q.size();
      sb = s_cyc_q.size();
      for (int i = 1; i <= 8; i++) send_beat(DW'(i), i == 8);
      idle(3);
      chk("t2_count", 64'(got_q.size() - gb), 64'd2);
      chk_beat("t2_b0", gb, 64'h04030201, 64'hF, 64'd0);
      chk_beat("t2_b1", gb + 1, 64'h08070605, 64'hF, 64'd1);
      if (got_cyc_q.size() >= gb + 2 && s_cyc_q.size() >= sb + 8) begin
         chk("t2_lat0", 64'(got_cyc_q[gb] - s_cyc_q[sb + 3]), 64'd1);
         chk("t2_lat1", 64'(got_cyc_q[gb + 1] - s_cyc_q[sb + 7]), 64'd1);
      end else begin
         flag_fail("t2_lat_present", got_cyc_q.size() - gb, 2);
      end

      // Short packets back-to-back
      gb = got_q.size();
      send_beat(8'hAA, 1'b1);
      send_beat(8'hB1, 1'b0);
      send_beat(8'hB2, 1'b0);
      send_beat(8'hB3, 1'b1);
      idle(3);
      chk("t3_count", 64'(got_q.size() - gb), 64'd2);
      chk_beat("t3_b0", gb, 64'h000000AA, 64'h1, 64'd1);
      chk_beat("t3_b1", gb + 1, 64'h00B3B2B1, 64'h7, 64'd1);

      // Backpressure
      mr_force = 1'b0;
      gb = got_q.size();
      sb = s_cyc_q.size();
      rise_cyc = -1;
      fork
         begin
            for (int i = 1; i <= 5; i++) send_beat(DW'(8'h20 + i), i == 5);
         end
         begin
            idle(8);
            @(negedge aclk);
            chk("t4_stall_tready", 64'(bus.s_tready), 64'd0);
            chk("t4_stall_tvalid", 64'(bus.m_tvalid), 64'd1);
            chk("t4_held_tdata",   64'(bus.m_tdata),  64'h24232221);
            chk("t4_accepted",     64'(s_cyc_q.size() - sb), 64'd4);
            @(posedge aclk); #1;
            mr_force = 1'b1;
            @(negedge aclk);
            rise_cyc = cyc;
            chk("t4_rise_tready", 64'(bus.s_tready), 64'd1);
            @(posedge aclk); #1;
         end
      join
      idle(3);
      chk("t4_count", 64'(got_q.size() - gb), 64'd2);
      chk_beat("t4_b0", gb, 64'h24232221, 64'hF, 64'd0);
      chk_beat("t4_b1", gb + 1, 64'h00000025, 64'h1, 64'd1);
      if (s_cyc_q.size() >= sb + 5 && got_cyc_q.size() >= gb + 1) begin
         chk("t4_b5_same_cycle", 64'(s_cyc_q[sb + 4]), 64'(rise_cyc));
         chk("t4_b0_taken",      64'(got_cyc_q[gb]),   64'(rise_cyc));
      end else begin
         flag_fail("t4_beats_present", s_cyc_q.size() - sb, 5);
      end

      // Random stress
      base_sl    = s_last_cnt;
      base_ml    = m_last_cnt;
      base_lanes = lanes_out;
      base_acc   = s_cyc_q.size();
      sent       = 0;
      mr_rand    = 1'b1;
      while (sent < 10000) begin
         len = $urandom_range(1, 17);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_beat(DW'($urandom), i == len - 1);
            sent++;
         end
      end
      mr_rand  = 1'b0;
      mr_force = 1'b1;
      w = 0;
      while ((exp_q.size() != 0 || bus.m_tvalid) && w < 50) begin
         idle(1);
         w++;
      end
      if (w >= 50) flag_fail("t5_drain_cycles", w, 50);
      idle(2);
      chk("t5_tlast_count", 64'(m_last_cnt - base_ml), 64'(s_last_cnt - base_sl));
      chk("t5_lanes_out",   64'(lanes_out - base_lanes), 64'(sent));
      chk("t5_accepted",    64'(s_cyc_q.size() - base_acc), 64'(sent));

      // Mid-packet reset
      send_beat(8'h31, 1'b0);
      send_beat(8'h32, 1'b0);
      pulse_reset();
      @(negedge aclk);
      chk("t6a_tvalid", 64'(bus.m_tvalid), 64'd0);
      @(posedge aclk); #1;
      gb = got_q.size();
      for (int i = 1; i <= 4; i++) send_beat(DW'(8'h10 + i), i == 4);
      idle(3);
      chk("t6a_count", 64'(got_q.size() - gb), 64'd1);
      chk_beat("t6a_b0", gb, 64'h14131211, 64'hF, 64'd1);

      // Reset while a wide beat is held
      mr_force = 1'b0;
      for (int i = 1; i <= 4; i++) send_beat(DW'(8'h40 + i), 1'b0);
      idle(3);
      @(negedge aclk);
      chk("t6b_held_tvalid", 64'(bus.m_tvalid), 64'd1);
      @(posedge aclk); #1;
      pulse_reset();
      @(negedge aclk);
      chk("t6b_tvalid", 64'(bus.m_tvalid), 64'd0);
      @(posedge aclk); #1;
      mr_force = 1'b1;
      gb = got_q.size();
      for (int i = 1; i <= 4; i++) send_beat(DW'(8'h10 + i), i == 4);
      idle(3);
      chk("t6b_count", 64'(got_q.size() - gb), 64'd1);
      chk_beat("t6b_b0", gb, 64'h14131211, 64'hF, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axis_width_upsizer.md
# axis_width_upsizer

Single-clock AXI-Stream width converter that sits directly downstream of the async AXI-Stream FIFO, in the read (consumer) clock domain. It packs RATIO narrow beats (DATA_WIDTH bits each) into one wide beat of DATA_WIDTH*RATIO bits with a per-lane keep mask. A tlast on any narrow beat closes the wide beat early, so a packet never shares a wide beat with the next packet.

## Interface

Parameters:
- DATA_WIDTH, 8: width of one narrow (input) beat and of one output lane.
- RATIO, 4: narrow beats per wide beat; legal values ≥ 2.

Ports:
- aclk  input  1  single clock; all logic is rising-edge.
- areset  input  1  asynchronous, active-high reset.
- s_tdata  input  DATA_WIDTH  narrow beat data, fed from the FIFO read side.
- s_tvalid  input  1  narrow beat valid.
- s_tready  output  1  narrow beat ready.
- s_tlast  input  1  last narrow beat of packet.
- m_tdata  output  DATA_WIDTH*RATIO  wide beat; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_tkeep  output  RATIO  lane k holds valid data when bit k is 1.
- m_tvalid  output  1  wide beat valid.
- m_tready  input  1  wide beat ready.
- m_tlast  output  1  wide beat carries the packet's final narrow beat.

## Operation

- Internal state:
  - lane index idx, range 0..RATIO-1, width clog2(RATIO).
  - accumulator acc_data, DATA_WIDTH*RATIO bits.
  - accumulator keep acc_keep, RATIO bits.
  - registered output stage m_tdata, m_tkeep, m_tlast, m_tvalid.
- Narrow accept: s_fire = s_tvalid & s_tready.
- Wide accept: m_fire = m_tvalid & m_tready.
- s_tready = !areset & (!m_tvalid | m_tready).
  - The input is stalled only while a wide beat is held and not being taken.
  - No s_tready dependence on s_tvalid or s_tlast.
- On s_fire, the beat is written into lane idx. The first narrow beat of each wide beat goes in lane 0, which is the LSBs.
- Word completes on s_fire when idx == RATIO-1, or when s_tlast == 1.
- On completion:
  - The output stage loads acc_data with lane idx replaced by s_tdata.
  - m_tkeep = acc_keep | (1<<idx), which is always contiguous from bit 0.
  - m_tlast = s_tlast and m_tvalid = 1.
  - idx, acc_data and acc_keep clear to 0.
  - Lanes above idx are zero in m_tdata.
- When the beat does not complete a word: acc lane idx is written, acc_keep[idx] is set, and idx increments.
- Output stage:
  - On m_fire with no simultaneous completion, m_tvalid goes to 0. m_tdata, m_tkeep and m_tlast hold their values.
  - On m_fire in the same cycle as a completion, the new word loads and m_tvalid stays 1. This gives back-to-back wide beats with no bubble.
  - While m_tvalid & !m_tready, all m_* outputs are stable (AXI rule).
- Packet boundary: RATIO=4, a 6-beat packet becomes 2 wide beats with keep 4'b1111 then 4'b0011, and m_tlast = 1 on the second. The next packet starts in lane 0.
- A 1-beat packet yields one wide beat with keep 4'b0001 and m_tlast = 1.
- Idle: a partially filled accumulator is held indefinitely. No timeout flush.
- Reset (assert at any time, including mid-packet or while a wide beat is held):
  - idx = 0, acc_data = 0, acc_keep = 0.
  - m_tvalid = 0, m_tdata = 0, m_tkeep = 0, m_tlast = 0.
  - s_tready = 0 while areset is high.
  - Partial words and held words are discarded.
  - The first beat after reset release goes to lane 0.

## Timing

- Latency: the wide beat is presented (m_tvalid = 1) on the cycle after the completing narrow beat's s_fire.
- Throughput:
  - Sustains one narrow beat per cycle while m_tready stays high, i.e. one wide beat every RATIO cycles.
  - Sustains one wide beat per cycle for 1-beat packets.
- Backpressure:
  - m_tready low with m_tvalid high drops s_tready combinationally in the same cycle.
  - When m_tready rises, s_tready rises in the same cycle. There is no lost cycle.
- Reset release: s_tready may go high in the first cycle areset is low. Outputs show their reset values until the first completion.
- Combinational paths: only m_tready → s_tready. All m_* outputs come straight from flops.

## Test plan

- Reset values:
  - Assert areset and hold it 3 cycles → all m_* are 0 and s_tready = 0.
  - Release areset → s_tready = 1 next cycle, and m_tvalid stays 0 with no input.
- Full-rate packing:
  - Stimulus: RATIO=4, m_tready = 1, stream bytes 0x01..0x08, s_tlast on 0x08.
  - Response: two wide beats, 0x04030201 with keep 0xF and last 0, then 0x08070605 with keep 0xF and last 1. Each appears 1 cycle after its 4th byte is accepted.
- Short packets:
  - Stimulus: packets {0xAA}(last), {0xB1,0xB2,0xB3}(last), sent back-to-back.
  - Response: 0x000000AA with keep 0x1 and last 1, then 0x00B3B2B1 with keep 0x7 and last 1. The second packet starts in lane 0.
- Backpressure:
  - Stimulus: hold m_tready = 0 while sending 5 bytes.
  - Response:
    - The first wide beat is held stable.
    - s_tready drops after byte 4 is accepted, and byte 5 stalls.
    - Raising m_tready accepts byte 5 in the same cycle.
    - Data is neither lost nor duplicated.
- Random stress:
  - Stimulus: random s_tvalid, m_tready and packet lengths 1..17, for 10k beats.
  - Response: the scoreboard's unpacked stream equals the input stream, keep is contiguous from bit 0, and m_tlast count equals s_tlast count.
- Mid-operation reset:
  - Stimulus: pulse areset after 2 bytes of a packet, and again while a wide beat is held under m_tready = 0.
  - Response: each pulse drops m_tvalid, and the next bytes 0x11..0x14 emerge as 0x14131211 with keep 0xF.
